// File: rtl/avalon_sdr_responder_if.sv
// Avalon-MM 16-bit slave port bundle between an SDRAM-side master and the responder.
// Carries request (address/read/write/writedata/byteenable) and response
// (readdata/readdatavalid/waitrequest); clock and reset stay outside the bundle.
interface avalon_sdr_responder_if;
    logic [31:0] avs_s0_address;
    logic        avs_s0_read;
    logic        avs_s0_write;
    logic [15:0] avs_s0_writedata;
    logic [1:0]  avs_s0_byteenable;
    logic [15:0] avs_s0_readdata;
    logic        avs_s0_readdatavalid;
    logic        avs_s0_waitrequest;

    modport slave (
        input  avs_s0_address,
        input  avs_s0_read,
        input  avs_s0_write,
        input  avs_s0_writedata,
        input  avs_s0_byteenable,
        output avs_s0_readdata,
        output avs_s0_readdatavalid,
        output avs_s0_waitrequest
    );

    modport master (
        output avs_s0_address,
        output avs_s0_read,
        output avs_s0_write,
        output avs_s0_writedata,
        output avs_s0_byteenable,
        input  avs_s0_readdata,
        input  avs_s0_readdatavalid,
        input  avs_s0_waitrequest
    );
endinterface

// File: rtl/avalon_sdr_responder.sv
// Avalon-MM scratch memory / SDRAM model: DEPTH halfwords, byte-enabled writes, in-order reads.
// Latency: read data returned READ_LATENCY edges after accept; writes complete at the accept edge.
// Backpressure: waitrequest = stall_in | MAX_PENDING reads outstanding | reset held.
//
// Ports: clk, reset (async, active-low); avs (slave modport of avalon_sdr_responder_if);
//        stall_in forces waitrequest; rd_count/wr_count count accepted requests (wrapping);
//        err is a sticky flag for out-of-range accesses and read+write collisions.
module avalon_sdr_responder #(
    parameter int          DEPTH        = 4096,
    parameter int          READ_LATENCY = 3,
    parameter int          MAX_PENDING  = 4,
    parameter logic [15:0] OOR_DATA     = 16'hDEAD
) (
    input  logic                  clk,
    input  logic                  reset,
    avalon_sdr_responder_if.slave avs,
    input  logic                  stall_in,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count,
    output logic                  err
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [15:0] mem [DEPTH];

    logic [3:0]       pending;
    logic [30:0]      hw_idx;
    logic             in_range;
    logic [IDX_W-1:0] mem_idx;
    logic             acc_wr;
    logic             acc_rd;
    logic             rw_clash;
    logic [15:0]      rd_dat;
    logic             ret_vld;

    // Return pipeline: stage 0 is loaded at the accept edge, the last stage drives the port.
    logic [READ_LATENCY-1:0]       vld_pipe;
    logic [READ_LATENCY-1:0][15:0] dat_pipe;
    logic [READ_LATENCY-1:0]       vld_next;
    logic [READ_LATENCY-1:0][15:0] dat_next;

    // Uses only registered pending so a return in this cycle cannot open the port early.
    assign avs.avs_s0_waitrequest = stall_in | (pending == 4'(MAX_PENDING)) | ~reset;

    assign hw_idx   = avs.avs_s0_address[31:1];
    assign in_range = (hw_idx < 31'(DEPTH));
    assign mem_idx  = hw_idx[IDX_W-1:0];

    // A request with both read and write set performs the write only; the read is dropped.
    assign acc_wr   = avs.avs_s0_write & ~avs.avs_s0_waitrequest;
    assign acc_rd   = avs.avs_s0_read & ~avs.avs_s0_write & ~avs.avs_s0_waitrequest;
    assign rw_clash = avs.avs_s0_read & avs.avs_s0_write & ~avs.avs_s0_waitrequest;

    // Sampled before this edge's write lands, so a write is seen by reads from the next edge on.
    assign rd_dat = in_range ? mem[mem_idx] : OOR_DATA;

    assign vld_next = (vld_pipe << 1) | READ_LATENCY'(acc_rd);
    assign dat_next = (dat_pipe << 16) | (READ_LATENCY*16)'(rd_dat);
    assign ret_vld  = vld_pipe[READ_LATENCY-1];

    assign avs.avs_s0_readdatavalid = ret_vld;
    assign avs.avs_s0_readdata      = dat_pipe[READ_LATENCY-1];

    // Memory is deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (acc_wr && in_range) begin
            if (avs.avs_s0_byteenable[0]) mem[mem_idx][7:0]  <= avs.avs_s0_writedata[7:0];
            if (avs.avs_s0_byteenable[1]) mem[mem_idx][15:8] <= avs.avs_s0_writedata[15:8];
        end
    end

    // Data stages only load alongside a valid, so the output holds the last returned word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe <= vld_next;
            for (int i = 0; i < READ_LATENCY; i++) begin
                if (vld_next[i]) dat_pipe[i] <= dat_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            rd_count <= '0;
            wr_count <= '0;
            err      <= 1'b0;
        end else begin
            pending  <= pending + {3'b000, acc_rd} - {3'b000, ret_vld};
            rd_count <= rd_count + 32'(acc_rd);
            wr_count <= wr_count + 32'(acc_wr);
            err      <= err | ((acc_wr | acc_rd) & ~in_range) | rw_clash;
        end
    end
endmodule

// File: tb/tb_avalon_sdr_responder.sv
module tb_avalon_sdr_responder;
    localparam int DEPTH = 4096;
    localparam int RL    = 4;
    localparam int MP    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic        err;

    avalon_sdr_responder_if avs();

    avalon_sdr_responder #(
        .DEPTH(DEPTH), .READ_LATENCY(RL), .MAX_PENDING(MP), .OOR_DATA(16'hDEAD)
    ) dut (
        .clk(clk), .reset(reset), .avs(avs), .stall_in(stall_in),
        .rd_count(rd_count), .wr_count(wr_count), .err(err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          outst  = 0;
    int          wait_hi = 0;
    int          lat_m;
    int          acc_q[$];
    logic [15:0] got[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Return monitor: collects read data, checks latency, outstanding bound and stall blocking.
    always @(negedge clk) begin
        if (!reset) begin
            acc_q.delete();
            outst = 0;
        end else begin
            if (avs.avs_s0_readdatavalid) begin
                got.push_back(avs.avs_s0_readdata);
                lat_m = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : -1;
                check("read_latency", 32'(lat_m), 32'(RL));
                if (outst > 0) outst--;
            end
            if (avs.avs_s0_read && !avs.avs_s0_write && !avs.avs_s0_waitrequest) begin
                acc_q.push_back(cyc);
                outst++;
            end
            check("pending_le_max", 32'(outst > MP), 32'd0);
            if (stall_in) check("stall_blocks", 32'(avs.avs_s0_waitrequest), 32'd1);
        end
    end

    task automatic issue(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [15:0] wd, input logic [1:0] be);
        int guard = 0;
        avs.avs_s0_address    = addr;
        avs.avs_s0_read       = rd;
        avs.avs_s0_write      = wr;
        avs.avs_s0_writedata  = wd;
        avs.avs_s0_byteenable = be;
        @(negedge clk);
        while (avs.avs_s0_waitrequest && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("accept_timeout", 32'(guard), 32'd0);
        @(posedge clk); #1;
        avs.avs_s0_read  = 1'b0;
        avs.avs_s0_write = 1'b0;
    endtask

    task automatic wait_returns(input int n);
        int guard = 0;
        while (got.size() < n && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("return_count", 32'(got.size()), 32'(n));
    endtask

    task automatic burst(input bit with_stall);
        int n = 0;
        int guard = 0;
        int stall_left;
        bit resumed = 1'b0;
        stall_left = with_stall ? 5 : 0;
        avs.avs_s0_read = 1'b1;
        while (n < 8 && guard < 200) begin
            avs.avs_s0_address = 32'(2 * n);
            stall_in = (n == 2 && stall_left > 0);
            @(negedge clk);
            if (stall_in) begin
                stall_left--;
            end else if (with_stall && n == 2 && !resumed) begin
                resumed = 1'b1;
                check("resume_after_stall", 32'(avs.avs_s0_waitrequest), 32'd0);
            end else if (avs.avs_s0_waitrequest) begin
                wait_hi++;
            end
            if (!avs.avs_s0_waitrequest) n++;
            @(posedge clk); #1;
            guard++;
        end
        avs.avs_s0_read = 1'b0;
        stall_in = 1'b0;
        check("burst_accepts", 32'(n), 32'd8);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sz;
        reset = 1'b0;
        stall_in = 1'b0;
        avs.avs_s0_address = '0;
        avs.avs_s0_read = 1'b0;
        avs.avs_s0_write = 1'b0;
        avs.avs_s0_writedata = '0;
        avs.avs_s0_byteenable = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_waitrequest", 32'(avs.avs_s0_waitrequest), 32'd1);
        check("rst_rdv", 32'(avs.avs_s0_readdatavalid), 32'd0);
        check("rst_readdata", 32'(avs.avs_s0_readdata), 32'd0);
        check("rst_rd_count", rd_count, 32'd0);
        check("rst_wr_count", wr_count, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b1;
        #1;
        check("wait_after_release", 32'(avs.avs_s0_waitrequest), 32'd0);

        // Basic write then read
        issue(32'd24, 1'b0, 1'b1, 16'h1234, 2'b11);
        issue(32'd24, 1'b1, 1'b0, 16'h0000, 2'b11);
        wait_returns(1);
        check("rd24_data", 32'(got[0]), 32'h1234);
        check("rd24_rd_count", rd_count, 32'd1);
        check("rd24_wr_count", wr_count, 32'd1);
        check("rd24_err", 32'(err), 32'd0);

        // Byte enables
        issue(32'd28, 1'b0, 1'b1, 16'hFFFF, 2'b11);
        issue(32'd28, 1'b0, 1'b1, 16'hAB00, 2'b10);
        issue(32'd28, 1'b1, 1'b0, 16'h0000, 2'b00);
        wait_returns(2);
        check("be_hi_data", 32'(got[1]), 32'hABFF);
        issue(32'd28, 1'b0, 1'b1, 16'h0000, 2'b00);
        check("be_none_wr_count", wr_count, 32'd4);
        issue(32'd28, 1'b1, 1'b0, 16'h0000, 2'b11);
        wait_returns(3);
        check("be_none_data", 32'(got[2]), 32'hABFF);
        check("be_rd_count", rd_count, 32'd3);

        // Back-to-back burst against the outstanding limit
        for (int i = 0; i < 8; i++) issue(32'(2 * i), 1'b0, 1'b1, 16'(16'h1000 + i), 2'b11);
        check("fill_wr_count", wr_count, 32'd12);
        burst(1'b0);
        wait_returns(11);
        check("burst_bubbles", 32'(wait_hi > 0), 32'd1);
        for (int i = 0; i < 8; i++) check("burst_data", 32'(got[3 + i]), 32'(16'h1000 + i));
        check("burst_rd_count", rd_count, 32'd11);

        // Burst with a 5-cycle stall after two accepts
        burst(1'b1);
        wait_returns(19);
        for (int i = 0; i < 8; i++) check("stall_burst_data", 32'(got[11 + i]), 32'(16'h1000 + i));
        check("stall_rd_count", rd_count, 32'd19);

        // Out-of-range read and read+write collision
        check("err_before_oor", 32'(err), 32'd0);
        issue(32'(2 * DEPTH), 1'b1, 1'b0, 16'h0000, 2'b11);
        wait_returns(20);
        check("oor_data", 32'(got[19]), 32'hDEAD);
        check("oor_err", 32'(err), 32'd1);
        check("oor_rd_count", rd_count, 32'd20);
        issue(32'd0, 1'b1, 1'b1, 16'h5A5A, 2'b11);
        repeat (RL + 2) begin @(posedge clk); #1; end
        check("rw_no_return", 32'(got.size()), 32'd20);
        check("rw_wr_count", wr_count, 32'd13);
        check("rw_rd_count", rd_count, 32'd20);
        check("rw_err_sticky", 32'(err), 32'd1);
        issue(32'd0, 1'b1, 1'b0, 16'h0000, 2'b11);
        wait_returns(21);
        check("rw_mem0", 32'(got[20]), 32'h5A5A);

        // Reset with reads in flight
        avs.avs_s0_address = 32'd2;
        avs.avs_s0_read = 1'b1;
        @(posedge clk); #1;
        avs.avs_s0_address = 32'd4;
        @(posedge clk); #1;
        avs.avs_s0_read = 1'b0;
        check("inflight_rd_count", rd_count, 32'd23);
        @(posedge clk); #1;
        reset = 1'b0;
        sz = got.size();
        #1;
        check("mid_rst_waitrequest", 32'(avs.avs_s0_waitrequest), 32'd1);
        check("mid_rst_rdv", 32'(avs.avs_s0_readdatavalid), 32'd0);
        check("mid_rst_readdata", 32'(avs.avs_s0_readdata), 32'd0);
        check("mid_rst_rd_count", rd_count, 32'd0);
        check("mid_rst_wr_count", wr_count, 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        check("inflight_lost", 32'(got.size()), 32'(sz));
        issue(32'd0, 1'b1, 1'b0, 16'h0000, 2'b11);
        wait_returns(sz + 1);
        check("mem_kept_over_reset", 32'(got[sz]), 32'h5A5A);
        check("post_rst_rd_count", rd_count, 32'd1);
        check("post_rst_wr_count", wr_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
